mult_iter_digit: RTL

Parametrised iterative multiplier that computes a WIDTH×WIDTH product by issuing one DIGIT×DIGIT partial product per clock through a single shared digit multiplier and accumulating the shifted results. It generalises the team's fixed-width 4-bit-digit decomposition to any WIDTH that is a multiple of DIGIT. It adds a signed mode and a valid/ready handshake on both sides, and trades throughput for area. It sits between operand producers and result consumers in the arithmetic datapath.

---
 rtl/mult_iter_digit_pkg.sv | 20 ++
 rtl/mult_digit_unit.sv | 15 +
 rtl/mult_iter_digit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mult_iter_digit_pkg.sv
// Shared types and elaboration helpers for the iterative digit multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide digits in a WIDTH-wide operand.
  function automatic int digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Index counter width; a single digit still needs one bit.
  function automatic int cnt_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/mult_digit_unit.sv
// Combinational unsigned DIGIT x DIGIT multiplier; the one place to swap in
// a different partial-product implementation.
module mult_digit_unit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0]   a,
  input  logic [DIGIT-1:0]   b,
  output logic [2*DIGIT-1:0] prod
);

  localparam int PW = 2 * DIGIT;

  assign prod = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_iter_digit.sv
// Iterative WIDTH x WIDTH multiplier: one digit partial product per cycle
// through a single shared digit multiplier, accumulated at its digit offset.
// Signed operands are handled as magnitudes with a final sign fix-up.
module mult_iter_digit
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int K  = digits(WIDTH, DIGIT);
  localparam int CW = cnt_w(K);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
      $error("mult_iter_digit: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [CW-1:0]      i_idx, j_idx;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg;
  logic [PW-1:0]      acc, p_reg;
  logic [DIGIT-1:0]   dig_a, dig_b;
  logic [2*DIGIT-1:0] dprod;
  logic [PW-1:0]      term, sum;
  logic               last;
  int                 shamt;

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
  // which is still representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sm);
    return (sm && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  mult_digit_unit #(.DIGIT(DIGIT)) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .prod (dprod)
  );

  // Select current digits and align the partial product at offset DIGIT*(i+j).
  always_comb begin
    dig_a = mag_a[i_idx*DIGIT +: DIGIT];
    dig_b = mag_b[j_idx*DIGIT +: DIGIT];
    shamt = DIGIT * (int'(i_idx) + int'(j_idx));
    term  = PW'(dprod) << shamt;
    sum   = acc + term;
    last  = (i_idx == LAST) && (j_idx == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit counters, accumulation and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_idx <= '0;
      j_idx <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      p_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a <= magnitude(a, signed_mode);
            mag_b <= magnitude(b, signed_mode);
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            i_idx <= '0;
            j_idx <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (last) begin
            p_reg <= neg ? (~sum + 1'b1) : sum;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
          end else begin
            acc <= sum;
            if (j_idx == LAST) begin
              j_idx <= '0;
              i_idx <= i_idx + 1'b1;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign p = p_reg;

endmodule
